// File: rtl/chunk_add_seq_pkg.sv
// chunk_add_seq_pkg: FSM state encoding shared by the chunked adder controller.
package chunk_add_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/chunk_add_seq_if.sv
// chunk_add_seq_if: operand (in_*) and result (out_*) valid/ready handshakes.
interface chunk_add_seq_if #(
    parameter int SIZE   = 4,
    parameter int CHUNKS = 4
);
    localparam int W = SIZE * CHUNKS;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout);
    modport slave (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout);
endinterface

// File: rtl/chunk_add_seq_rca.sv
// chunk_rca: SIZE-bit ripple-carry adder built from full-adder cells.
module chunk_rca #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] a_s,
    input  logic [SIZE-1:0] b_s,
    input  logic            c_in,
    output logic [SIZE-1:0] s,
    output logic            c_out
);
    logic [SIZE:0] c;
    assign c[0]  = c_in;
    assign c_out = c[SIZE];
    for (genvar i = 0; i < SIZE; i++) begin : g_fa
        assign s[i]   = a_s[i] ^ b_s[i] ^ c[i];
        assign c[i+1] = (a_s[i] & b_s[i]) | (c[i] & (a_s[i] ^ b_s[i]));
    end
endmodule

// File: rtl/chunk_add_seq.sv
// chunk_add_seq: wide a+b+cin computed one SIZE-bit slice per cycle through a
// single ripple-carry adder, LSB slice first, with the slice carry registered.
module chunk_add_seq
    import chunk_add_seq_pkg::*;
#(
    parameter int SIZE   = 4,
    parameter int CHUNKS = 4
) (
    input logic            clk,
    input logic            rst_n,
    chunk_add_seq_if.slave bus
);
    localparam int W  = SIZE * CHUNKS;
    localparam int IW = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
    localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q;
    logic [W-1:0]    a_q, b_q, sum_q;
    logic            carry_q, cout_q;
    logic [SIZE-1:0] s;
    logic            c_out;
    logic            accept;

    chunk_rca #(.SIZE(SIZE)) u_rca (
        .a_s  (a_q[int'(idx_q)*SIZE +: SIZE]),
        .b_s  (b_q[int'(idx_q)*SIZE +: SIZE]),
        .c_in (carry_q),
        .s    (s),
        .c_out(c_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE && bus.in_valid)  ? RUN  :
                  (state_q == RUN  && idx_q == LAST) ? DONE :
                  (state_q == DONE && bus.out_ready) ? IDLE : state_q;
    end

    always_comb begin
        bus.in_ready  = state_q == IDLE;
        bus.out_valid = state_q == DONE;
    end

    assign accept   = bus.in_valid && bus.in_ready;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

    // idx stops at LAST so it never wraps; the next accept reloads it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            sum_q[int'(idx_q)*SIZE +: SIZE] <= s;
            carry_q <= c_out;
            if (idx_q == LAST) cout_q <= c_out;
            else               idx_q  <= idx_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_chunk_add_seq.sv
// tb_chunk_add_seq: scoreboard bench for chunk_add_seq with SIZE=4, CHUNKS=4.
module tb_chunk_add_seq;
    localparam int SIZE = 4, CHUNKS = 4, W = SIZE * CHUNKS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0, n_pass = 0;
    int   cyc = 0, last_acc = 0, prev_acc = 0, lat = 0;
    bit   stall_en = 1'b0;
    logic [W:0] sb[$];

    chunk_add_seq_if #(.SIZE(SIZE), .CHUNKS(CHUNKS)) bus ();
    chunk_add_seq #(.SIZE(SIZE), .CHUNKS(CHUNKS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Monitor: handshakes seen here complete on the following rising edge.
    always @(negedge clk) begin
        if (!rst_n) sb.delete();
        else begin
            if (bus.in_valid && bus.in_ready)
                sb.push_back({1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.cin});
            if (bus.out_valid && bus.out_ready) begin
                chk("sb_has_accept", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) chk("sb_result", {bus.cout, bus.sum}, sb.pop_front());
            end
        end
    end

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input bit hold);
        bus.a = av; bus.b = bv; bus.cin = cv; bus.in_valid = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (bus.in_ready) break;
            if (n == 300) begin
                $display("FAIL accept_timeout got=0 exp=1");
                $fatal(1, "accept timeout");
            end
            @(posedge clk); #1;
            if (stall_en) bus.out_ready = $urandom_range(0, 3) != 0;
        end
        prev_acc = last_acc;
        last_acc = cyc;
        @(posedge clk); #1;
        if (!hold) bus.in_valid = 1'b0;
        if (stall_en) bus.out_ready = $urandom_range(0, 3) != 0;
    endtask

    task automatic wait_out(input bit busy_chk);
        lat = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (busy_chk) chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
            if (bus.out_valid) return;
            lat++;
        end
        chk("out_valid_timeout", 64'(bus.out_valid), 64'd1);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sum", 64'(bus.sum), 64'd0);
        chk("rst_cout", 64'(bus.cout), 64'd0);
        @(posedge clk); #1;

        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_out(1'b0);
        chk("cp_latency", 64'(lat), 64'd4);
        chk("cp_sum", 64'(bus.sum), 64'h0000);
        chk("cp_cout", 64'(bus.cout), 64'd1);

        @(posedge clk); #1;
        send(16'h1234, 16'h4321, 1'b1, 1'b0);
        wait_out(1'b1);
        chk("nc_sum", 64'(bus.sum), 64'h5556);
        chk("nc_cout", 64'(bus.cout), 64'd0);

        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(16'h8000, 16'h8000, 1'b0, 1'b0);
        wait_out(1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1; bus.a = 16'h1111 * i; bus.b = 16'h0F0F; bus.cin = 1'b1;
            @(negedge clk);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_sum", 64'(bus.sum), 64'h0000);
            chk("bp_cout", 64'(bus.cout), 64'd1);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_out_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_idle_in_ready", 64'(bus.in_ready), 64'd1);

        @(posedge clk); #1;
        send(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mr_sum", 64'(bus.sum), 64'd0);
        chk("mr_cout", 64'(bus.cout), 64'd0);
        chk("mr_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        send(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_out(1'b0);
        chk("mr_fresh_sum", 64'(bus.sum), 64'h0002);
        chk("mr_fresh_cout", 64'(bus.cout), 64'd0);

        @(posedge clk); #1;
        send(16'hFEDC, 16'h0123, 1'b1, 1'b1);
        send(16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
        chk("b2b_gap1", 64'(last_acc - prev_acc), 64'd6);
        send(16'hC000, 16'h4000, 1'b0, 1'b0);
        chk("b2b_gap2", 64'(last_acc - prev_acc), 64'd6);

        stall_en = 1'b1;
        for (int i = 0; i < 1000; i++)
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        stall_en = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 50 && sb.size() > 0; n++) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("end_out_valid", 64'(bus.out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/chunk_add_seq.md
# chunk_add_seq

Multi-cycle wide adder controller that sits directly upstream of, and consumes the result of, the team's SIZE-bit ripple-carry adder. It accepts a W = SIZE*CHUNKS bit operand pair over a valid/ready handshake and feeds one SIZE-bit slice per cycle, LSB slice first, through a single ripple-carry instance. It registers the slice carry between cycles, assembles the full sum, and presents sum plus carry-out downstream over a second valid/ready handshake. This lets wide additions reuse one narrow adder with a short critical path.

## Interface
- SIZE, 4: slice width in bits; the width of the ripple-carry adder instance.
- CHUNKS, 4: number of slices per operation; must be ≥ 1.
- W (localparam), SIZE*CHUNKS: full operand width.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand pair a, b, cin is valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry into slice 0.
- out_valid  out  1  sum and cout are valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  W  registered sum, (a+b+cin) mod 2^W.
- cout  out  1  carry out of the top slice.

## Operation
- FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, capture a, b, cin into operand registers.
  - Set carry_q = cin, idx = 0, then go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle, the adder is fed a[idx*SIZE +: SIZE], b[idx*SIZE +: SIZE] and carry_q.
  - Its slice sum is written to sum[idx*SIZE +: SIZE], and its top carry goes to carry_q.
  - idx increments each cycle.
  - When idx == CHUNKS-1, that cycle's carry goes to cout and the FSM moves to DONE.
- DONE:
  - out_valid = 1; sum and cout are held stable.
  - On out_ready, go to IDLE and clear out_valid.
  - No new operand is accepted in the same cycle as the output handshake.
- in_ready is a combinational decode of state == IDLE. out_valid is a decode of state == DONE.
- Operand registers are only written on the input handshake. Input changes outside the handshake have no effect.
- sum and cout keep their last values after leaving DONE. They are only meaningful while out_valid = 1.
- idx is $clog2(CHUNKS) bits wide, minimum 1. It never wraps past CHUNKS-1.
- Reset (rst_n low at a rising edge), from any state including mid-RUN or DONE:
  - state = IDLE, idx = 0, carry_q = 0, sum = 0, cout = 0.
  - The in-flight operation is discarded and no partial result is emitted.
  - Next cycle, in_ready = 1 and out_valid = 0.

## Timing
- Input handshake at edge k puts the FSM in RUN for cycles k+1 … k+CHUNKS.
- out_valid first rises after edge k+CHUNKS, so latency is CHUNKS cycles from accept to out_valid.
- Back-to-back throughput is one operation per CHUNKS+2 cycles with out_ready held at 1.
- Backpressure: out_valid, sum and cout are held indefinitely while out_ready = 0, and in_ready stays 0.
- CHUNKS = 1: RUN lasts a single cycle, with the same handshake rules.
- The critical path is one SIZE-bit ripple chain plus the slice mux, independent of W.

## Structure
- Shared package holds only the FSM state encoding (IDLE, RUN, DONE) as a typedef.
- One sub-module, chunk_rca: a SIZE-bit ripple-carry adder built from full-adder cells.
  - Inputs: a_s, b_s, c_in.
  - Outputs: s, c_out.
  - Instantiated exactly once.
- Slice select and sum write-back are indexed part-selects. There are no per-slice adder copies.

## Test plan
All scenarios use SIZE=4, CHUNKS=4.
- Carry propagate: a=16'hFFFF, b=16'h0001, cin=0, accept at edge k. Required: out_valid after edge k+4, sum=16'h0000, cout=1.
- No carry: a=16'h1234, b=16'h4321, cin=1. Required: sum=16'h5556, cout=0, in_ready=0 throughout RUN and DONE.
- Backpressure: a=16'h8000, b=16'h8000, cin=0, out_ready=0 for 5 cycles after out_valid. Required:
  - sum=16'h0000 and cout=1 held stable.
  - in_valid pulses are ignored.
  - Return to IDLE one edge after out_ready=1.
- Reset mid-RUN: accept a=16'hAAAA, b=16'h5555, then drive rst_n=0 on the 2nd RUN cycle. Required:
  - Next cycle: out_valid=0, sum=0, cout=0, in_ready=1.
  - A fresh a=16'h0001, b=16'h0001 then yields sum=16'h0002, cout=0.
- Back-to-back: in_valid held with 3 operand pairs queued, out_ready=1. Required:
  - Accepts spaced exactly 6 cycles apart.
  - Every result matches a reference model (a+b+cin) including cout.
- Random: 1000 random a, b, cin with random out_ready stalls. Required: scoreboard match and no out_valid without a preceding accept.
